// File: rtl/modport_counter_pkg.sv
// modport_counter_pkg: shared width, count type, direction encoding and count limits
package modport_counter_pkg;
  localparam int COUNT_W = 4;
  typedef logic [COUNT_W-1:0] count_t;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  localparam count_t COUNT_MAX = '1;
  localparam count_t COUNT_MIN = '0;
endpackage

// File: rtl/modport_counter_next.sv
// modport_counter_next: next-count logic; MODPORT_COUNTER_SATURATE_EN makes counting saturate instead of wrap
module modport_counter_next
  import modport_counter_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic [WIDTH-1:0] count,
  input  logic             load,
  input  logic             updown,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count_next
);
  logic             up;
  logic [WIDTH-1:0] stepped;
  assign up      = (updown == DIR_UP);
  assign stepped = up ? count + WIDTH'(1) : count - WIDTH'(1);
`ifdef MODPORT_COUNTER_SATURATE_EN
  logic at_limit;
  assign at_limit   = up ? (count == {WIDTH{1'b1}}) : (count == {WIDTH{1'b0}});
  assign count_next = load ? data : at_limit ? count : stepped;
`else
  assign count_next = load ? data : stepped;
`endif
endmodule

// File: rtl/modport_counter.sv
// modport_counter: loadable up/down counter register with sync active-low reset; saturates under MODPORT_COUNTER_SATURATE_EN
module modport_counter
  import modport_counter_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             updown,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_out
);
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  modport_counter_next #(.WIDTH(WIDTH)) u_next (
    .count      (count),
    .load       (load),
    .updown     (updown),
    .data       (data),
    .count_next (count_next)
  );
  always_ff @(posedge clk) begin
    if (!rst) count <= '0;
    else count <= count_next;
  end
  assign data_out = count;
endmodule

// File: tb/tb_modport_counter.sv
// tb_modport_counter: directed self-checking bench for modport_counter (wrap or MODPORT_COUNTER_SATURATE_EN build)
module tb_modport_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       updown = 1'b0;
  logic [3:0] data = 4'h0;
  logic [3:0] data_out;
  int         checks = 0;
  int         errors = 0;
  modport_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .updown   (updown),
    .data     (data),
    .data_out (data_out)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [3:0] exp [5] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3};
    for (int i = 0; i < 5; i++) begin
      rst = (i >= 2); load = (i < 2); data = 4'hA; updown = 1'b1;
      tick();
      checks++;
      if (data_out !== exp[i]) begin
        errors++;
        $display("FAIL reset[%0d]: data_out=%h expected %h", i, data_out, exp[i]);
      end
    end
  endtask
  task automatic test_load_up();
    logic [3:0] exp [4] = '{4'h5, 4'h6, 4'h7, 4'h8};
    for (int i = 0; i < 4; i++) begin
      load = (i == 0); data = 4'h5; updown = 1'b1;
      tick();
      checks++;
      if (data_out !== exp[i]) begin
        errors++;
        $display("FAIL load_up[%0d]: data_out=%h expected %h", i, data_out, exp[i]);
      end
    end
  endtask
  task automatic test_up_wrap();
`ifdef MODPORT_COUNTER_SATURATE_EN
    logic [3:0] exp [4] = '{4'hE, 4'hF, 4'hF, 4'hF};
`else
    logic [3:0] exp [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
`endif
    for (int i = 0; i < 4; i++) begin
      load = (i == 0); data = 4'hE; updown = 1'b1;
      tick();
      checks++;
      if (data_out !== exp[i]) begin
        errors++;
        $display("FAIL up_wrap[%0d]: data_out=%h expected %h", i, data_out, exp[i]);
      end
    end
  endtask
  task automatic test_down_wrap();
`ifdef MODPORT_COUNTER_SATURATE_EN
    logic [3:0] exp [4] = '{4'h1, 4'h0, 4'h0, 4'h0};
`else
    logic [3:0] exp [4] = '{4'h1, 4'h0, 4'hF, 4'hE};
`endif
    for (int i = 0; i < 4; i++) begin
      load = (i == 0); data = 4'h1; updown = 1'b0;
      tick();
      checks++;
      if (data_out !== exp[i]) begin
        errors++;
        $display("FAIL down_wrap[%0d]: data_out=%h expected %h", i, data_out, exp[i]);
      end
    end
  endtask
  task automatic test_load_priority();
    logic       ld  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       ud  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] dv  [4] = '{4'h6, 4'h6, 4'h3, 4'h3};
    logic [3:0] exp [4] = '{4'h6, 4'h7, 4'h3, 4'h2};
    for (int i = 0; i < 4; i++) begin
      load = ld[i]; updown = ud[i]; data = dv[i];
      tick();
      checks++;
      if (data_out !== exp[i]) begin
        errors++;
        $display("FAIL load_priority[%0d]: data_out=%h expected %h", i, data_out, exp[i]);
      end
    end
  endtask
  task automatic test_mid_reset();
    logic       rv  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef MODPORT_COUNTER_SATURATE_EN
    logic [3:0] exp [6] = '{4'h9, 4'h8, 4'h7, 4'h0, 4'h0, 4'h0};
`else
    logic [3:0] exp [6] = '{4'h9, 4'h8, 4'h7, 4'h0, 4'hF, 4'hE};
`endif
    for (int i = 0; i < 6; i++) begin
      rst = rv[i]; load = (i == 0); data = 4'h9; updown = 1'b0;
      tick();
      checks++;
      if (data_out !== exp[i]) begin
        errors++;
        $display("FAIL mid_reset[%0d]: data_out=%h expected %h", i, data_out, exp[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] dv [4] = '{4'hC, 4'h0, 4'hF, 4'h4};
    for (int i = 0; i < 4; i++) begin
      rst = 1'b1; load = 1'b1; data = dv[i]; updown = i[0];
      tick();
      checks++;
      if (data_out !== dv[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: data_out=%h expected %h", i, data_out, dv[i]);
      end
    end
    load = 1'b0; updown = 1'b1;
    tick();
    checks++;
    if (data_out !== 4'h5) begin
      errors++;
      $display("FAIL back_to_back_count: data_out=%h expected 5", data_out);
    end
  endtask
  initial begin
    test_reset();
    test_load_up();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/modport_counter.md
# modport_counter

Loadable 4-bit up/down counter driven through a clocked bus interface (load, direction, data in; count out). It sits behind the team's counter bus interface: a BFM drives `load`/`updown`/`data` and a monitor samples all four signals on the rising clock edge. The count advances once per clock unless reset or load takes priority.

## Interface
- `WIDTH`, default 4, counter and data width in bits.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  reset, synchronous, active-low; takes effect on the rising edge of `clk` while low.
- `load`  input  1  when high, `data` is copied into the counter on the next edge.
- `updown`  input  1  count direction: 1 = up (+1), 0 = down (−1).
- `data`  input  WIDTH  parallel load value.
- `data_out`  output  WIDTH  current count, registered.

## Operation
- Priority at each rising edge of `clk`, highest first:
  1. `rst == 0`: the count becomes 0.
  2. `load == 1`: the count becomes `data`. `updown` is ignored.
  3. Otherwise the counter counts.
- Counting with `updown == 1`: count becomes count + 1, modulo 2^WIDTH. 15 → 0 when WIDTH = 4.
- Counting with `updown == 0`: count becomes count − 1, modulo 2^WIDTH. 0 → 15 when WIDTH = 4.
- There is no enable. The counter changes every cycle that is neither reset nor load.
- `data_out` is driven directly from the count register. It has no combinational path from any input.
- Reset value: `data_out = 0`.
- Reset asserted mid-count: the count clears on the first edge with `rst` low and holds 0 while `rst` stays low.
- Counting resumes on the first edge after `rst` returns high. That edge applies `load`/`updown` as normal.
- Load and count direction change together: load wins, and the loaded value appears unmodified.
- Unknown (X) inputs are not defined. The bench must drive every input to a known value from reset onward.

## Timing
- Latency is 1 cycle for every operation. An input sampled at edge N is reflected on `data_out` after edge N.
- The bench drives inputs with an output skew of 1 time unit after the clock edge. It samples `data_out` 1 time unit before the edge.
- The DUT must therefore settle `data_out` within the same cycle. This is met by any registered output.
- Reset is synchronous: no asynchronous clear, and `rst` is not in the sensitivity list.

## Configuration
- `MODPORT_COUNTER_SATURATE_EN` defined: counting saturates instead of wrapping.
  - Up at all-ones holds all-ones.
  - Down at 0 holds 0.
  - Load and reset are unchanged.
- `MODPORT_COUNTER_SATURATE_EN` undefined (default): modulo wrap-around as in Operation.

## Structure
- Package `modport_counter_pkg`:
  - `localparam int COUNT_W = 4`
  - `typedef logic [COUNT_W-1:0] count_t`
  - `typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e`
  - constants `COUNT_MAX` (all ones) and `COUNT_MIN` (0)
- Sub-module `modport_counter_next`: purely combinational next-count logic.
  - Inputs: current count, `load`, `data`, `updown`.
  - Output: next count.
  - Contains the wrap/saturate selection under `MODPORT_COUNTER_SATURATE_EN`.
- Top-level `modport_counter`: the register, the synchronous reset and the output assignment only.

## Test plan
- Reset: hold `rst = 0` for 2 cycles with `load = 1`, `data = 4'hA` → `data_out = 0` after each edge. Release `rst` with `load = 0`, `updown = 1` → `data_out` goes 1, 2, 3.
- Load then count up: `load = 1`, `data = 4'h5`, then `load = 0`, `updown = 1` for 3 cycles → `data_out` goes 5, 6, 7, 8.
- Up wrap: load `4'hE`, count up 3 cycles → E, F, 0, 1. With `MODPORT_COUNTER_SATURATE_EN` → E, F, F, F.
- Down wrap: load `4'h1`, `updown = 0` for 3 cycles → 1, 0, F, E. With `MODPORT_COUNTER_SATURATE_EN` → 1, 0, 0, 0.
- Load priority: count at 7 counting up, then assert `load = 1`, `data = 4'h3` with `updown = 0` → `data_out = 3` next cycle, not 6 or 8. Release `load` with `updown = 0` → 2.
- Mid-count reset: count down from 9, assert `rst = 0` for 1 cycle after reaching 7 → `data_out = 0`. Release with `updown = 0` → F (wrap build) or 0 (saturate build).
